mcu_subsys_bus_decoder: RTL and testbench

//  Parametrised N-target address decoder for the picorv32 native memory bus; successor to the fixed
//  ROM/SRAM/peripheral host bridge. Sits between the CPU and NUM_TGT slaves (ROM, SRAM, peripheral

---
 rtl/mcu_subsys_bus_decoder.sv | 233 +++++++++++++++++++++++
 tb/tb_mcu_subsys_bus_decoder.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_subsys_bus_decoder.sv
// -----------------------------------------------------------------------------
// mcu_subsys_bus_decoder
//
// Address decoder for the picorv32 native memory bus. It sits between the CPU
// and NUM_TGT slaves and adds the following:
//   - a configurable base/mask address map,
//   - decode-error responses,
//   - error capture (sticky flag, last address, saturating count),
//   - an optional per-transaction watchdog.
//
// Each CPU request is served by a single FSM:
//   IDLE -> ACTIVE -> RESP   (address hits target i)
//   IDLE -> ERR    -> RESP   (address hits no target)
// All outputs are registered.
//
// Optional feature:
//   `define MCU_BUS_TIMEOUT_EN  enables the ACTIVE-state watchdog. After
//   TIMEOUT_CYC cycles with no target ready, the access is aborted and
//   answered with an error. When the macro is undefined, ACTIVE waits
//   indefinitely for the target.
//
// Ports:
//   sys_clk, rst        clock; synchronous active-high reset
//   cpu_mem_valid       CPU request valid, held until cpu_mem_ready
//   cpu_mem_ready       one-cycle response strobe to the CPU
//   cpu_mem_addr        CPU byte address
//   cpu_mem_wdata       CPU write data
//   cpu_mem_wstrb       CPU byte strobes (0 = read)
//   cpu_mem_rdata       registered read data (ERR_RDATA on error)
//   tgt_mem_valid       one-hot request valid, one bit per target
//   tgt_mem_ready       per-target ready
//   tgt_mem_addr        broadcast address to all targets
//   tgt_mem_wdata       broadcast write data to all targets
//   tgt_mem_wstrb       broadcast byte strobes to all targets
//   tgt_mem_rdata       per-target read data, target i at [32*i +: 32]
//   err_clr             clears err_valid, err_addr and err_cnt
//   err_valid           sticky error flag
//   err_addr            address of the most recent error
//   err_cnt             saturating error count (stops at 8'hFF)
// -----------------------------------------------------------------------------
module mcu_subsys_bus_decoder #(
  parameter int                   NUM_TGT     = 4,
  parameter logic [NUM_TGT*32-1:0] TGT_BASE   = {NUM_TGT{32'h0000_0000}},
  parameter logic [NUM_TGT*32-1:0] TGT_MASK   = {NUM_TGT{32'hFFFF_0000}},
  parameter logic [31:0]          ERR_RDATA   = 32'hDEAD_BEEF,
  parameter int                   TIMEOUT_CYC = 256
) (
  input  logic                    sys_clk,
  input  logic                    rst,
  input  logic                    cpu_mem_valid,
  output logic                    cpu_mem_ready,
  input  logic [31:0]             cpu_mem_addr,
  input  logic [31:0]             cpu_mem_wdata,
  input  logic [3:0]              cpu_mem_wstrb,
  output logic [31:0]             cpu_mem_rdata,
  output logic [NUM_TGT-1:0]      tgt_mem_valid,
  input  logic [NUM_TGT-1:0]      tgt_mem_ready,
  output logic [31:0]             tgt_mem_addr,
  output logic [31:0]             tgt_mem_wdata,
  output logic [3:0]              tgt_mem_wstrb,
  input  logic [NUM_TGT*32-1:0]   tgt_mem_rdata,
  input  logic                    err_clr,
  output logic                    err_valid,
  output logic [31:0]             err_addr,
  output logic [7:0]              err_cnt
);

  // Reject parameter values that the hardware cannot honour.
  if (NUM_TGT < 1 || NUM_TGT > 8) begin : g_bad_num_tgt
    $error("mcu_subsys_bus_decoder: NUM_TGT must be in 1..8");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("mcu_subsys_bus_decoder: TIMEOUT_CYC must be in 1..65535");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_ERR,
    ST_RESP
  } state_t;

  state_t               r_state;

  logic                 w_hit;
  logic [NUM_TGT-1:0]   w_hit_oh;
  logic                 w_sel_ready;
  logic [31:0]          w_sel_rdata;
  logic                 w_timeout;
  logic                 w_err_rec;
  logic [7:0]           w_err_cnt_inc;

  // Address decode on the live CPU address.
  // The loop walks from the highest index down to the lowest, so the last
  // match written is the lowest-index hit. That gives lowest-index priority
  // when map entries overlap.
  // NOTE: every always_comb output gets a default before any conditional
  // assignment; otherwise a path that skips the assignment infers a latch.
  always_comb begin
    w_hit    = 1'b0;
    w_hit_oh = '0;
    for (int i = NUM_TGT - 1; i >= 0; i--) begin
      if ((cpu_mem_addr & TGT_MASK[32*i +: 32]) == TGT_BASE[32*i +: 32]) begin
        w_hit       = 1'b1;
        w_hit_oh    = '0;
        w_hit_oh[i] = 1'b1;
      end
    end
  end

  // Ready and read data from the target currently being served.
  // tgt_mem_valid is one-hot and is set only in ACTIVE, so ready from any
  // other target is masked off here.
  always_comb begin
    w_sel_ready = 1'b0;
    w_sel_rdata = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      if (tgt_mem_valid[i]) begin
        w_sel_ready = w_sel_ready | tgt_mem_ready[i];
        w_sel_rdata = tgt_mem_rdata[32*i +: 32];
      end
    end
  end

`ifdef MCU_BUS_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  logic [15:0] r_to_cnt;

  // Expiry fires on the TIMEOUT_CYC-th ACTIVE cycle without ready.
  // If ready arrives in that same cycle, ready takes priority.
  assign w_timeout = (r_state == ST_ACTIVE) && !w_sel_ready && (r_to_cnt == TO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  assign w_err_rec     = (r_state == ST_ERR) || w_timeout;
  assign w_err_cnt_inc = (err_cnt == 8'hFF) ? 8'hFF : err_cnt + 8'd1;

  // NOTE: sequential state uses non-blocking assignments only. All
  // registers then update together on the edge, regardless of the order
  // of statements in the block.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      cpu_mem_ready <= 1'b0;
      cpu_mem_rdata <= '0;
      tgt_mem_valid <= '0;
      tgt_mem_addr  <= '0;
      tgt_mem_wdata <= '0;
      tgt_mem_wstrb <= '0;
      err_valid     <= 1'b0;
      err_addr      <= '0;
      err_cnt       <= '0;
`ifdef MCU_BUS_TIMEOUT_EN
      r_to_cnt      <= '0;
`endif
    end else begin
      // The response strobe is high only for the single RESP cycle.
      cpu_mem_ready <= 1'b0;

      // Error capture. An error recorded in the same cycle as err_clr
      // overrides the clear, so err_cnt restarts at 1.
      if (err_clr) begin
        err_valid <= 1'b0;
        err_addr  <= '0;
        err_cnt   <= '0;
      end
      if (w_err_rec) begin
        err_valid <= 1'b1;
        err_addr  <= tgt_mem_addr;
        err_cnt   <= err_clr ? 8'd1 : w_err_cnt_inc;
      end

      case (r_state)
        ST_IDLE: begin
          if (cpu_mem_valid) begin
            tgt_mem_addr  <= cpu_mem_addr;
            tgt_mem_wdata <= cpu_mem_wdata;
            tgt_mem_wstrb <= cpu_mem_wstrb;
`ifdef MCU_BUS_TIMEOUT_EN
            r_to_cnt      <= '0;
`endif
            if (w_hit) begin
              tgt_mem_valid <= w_hit_oh;
              r_state       <= ST_ACTIVE;
            end else begin
              r_state       <= ST_ERR;
            end
          end
        end

        ST_ACTIVE: begin
          if (w_sel_ready) begin
            cpu_mem_rdata <= w_sel_rdata;
            tgt_mem_valid <= '0;
            cpu_mem_ready <= 1'b1;
            r_state       <= ST_RESP;
          end
`ifdef MCU_BUS_TIMEOUT_EN
          else if (w_timeout) begin
            cpu_mem_rdata <= ERR_RDATA;
            tgt_mem_valid <= '0;
            cpu_mem_ready <= 1'b1;
            r_state       <= ST_RESP;
          end else begin
            r_to_cnt      <= r_to_cnt + 16'd1;
          end
`endif
        end

        // Unmapped access: nothing reaches any target, so a write is
        // simply discarded.
        ST_ERR: begin
          cpu_mem_rdata <= ERR_RDATA;
          cpu_mem_ready <= 1'b1;
          r_state       <= ST_RESP;
        end

        // cpu_mem_ready is high in this cycle. The CPU may present its next
        // request in the following cycle, which IDLE will sample.
        ST_RESP: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcu_subsys_bus_decoder.sv
// -----------------------------------------------------------------------------
// tb_mcu_subsys_bus_decoder
//
// Directed bench for mcu_subsys_bus_decoder.
//
// Address map used here:
//   tgt0  base 0x0000_0000  mask 0xFFFF_0000
//   tgt1  base 0x0001_0000  mask 0xFFFF_0000
//   tgt2  base 0x0000_0000  mask 0xFFF0_0000  (overlaps tgt0 and tgt1)
//   tgt3  base 0x2000_0000  mask 0xFFFF_0000
//
// Timing: inputs are driven and outputs sampled on the falling edge of the
// clock.
// -----------------------------------------------------------------------------
module tb_mcu_subsys_bus_decoder;

  localparam int NT = 4;
  localparam logic [NT*32-1:0] BASE = {32'h2000_0000, 32'h0000_0000, 32'h0001_0000, 32'h0000_0000};
  localparam logic [NT*32-1:0] MASK = {32'hFFFF_0000, 32'hFFF0_0000, 32'hFFFF_0000, 32'hFFFF_0000};

  logic              clk;
  logic              rst;
  logic              cpu_mem_valid;
  logic              cpu_mem_ready;
  logic [31:0]       cpu_mem_addr;
  logic [31:0]       cpu_mem_wdata;
  logic [3:0]        cpu_mem_wstrb;
  logic [31:0]       cpu_mem_rdata;
  logic [NT-1:0]     tgt_mem_valid;
  logic [NT-1:0]     tgt_mem_ready;
  logic [31:0]       tgt_mem_addr;
  logic [31:0]       tgt_mem_wdata;
  logic [3:0]        tgt_mem_wstrb;
  logic [NT*32-1:0]  tgt_mem_rdata;
  logic              err_clr;
  logic              err_valid;
  logic [31:0]       err_addr;
  logic [7:0]        err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  mcu_subsys_bus_decoder #(
    .NUM_TGT     (NT),
    .TGT_BASE    (BASE),
    .TGT_MASK    (MASK),
    .ERR_RDATA   (32'hDEAD_BEEF),
    .TIMEOUT_CYC (8)
  ) dut (
    .sys_clk       (clk),
    .rst           (rst),
    .cpu_mem_valid (cpu_mem_valid),
    .cpu_mem_ready (cpu_mem_ready),
    .cpu_mem_addr  (cpu_mem_addr),
    .cpu_mem_wdata (cpu_mem_wdata),
    .cpu_mem_wstrb (cpu_mem_wstrb),
    .cpu_mem_rdata (cpu_mem_rdata),
    .tgt_mem_valid (tgt_mem_valid),
    .tgt_mem_ready (tgt_mem_ready),
    .tgt_mem_addr  (tgt_mem_addr),
    .tgt_mem_wdata (tgt_mem_wdata),
    .tgt_mem_wstrb (tgt_mem_wstrb),
    .tgt_mem_rdata (tgt_mem_rdata),
    .err_clr       (err_clr),
    .err_valid     (err_valid),
    .err_addr      (err_addr),
    .err_cnt       (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the run ever stalls outside a bounded wait.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1 ms, required to finish earlier");
    $fatal(1);
  end

  // Runs one CPU transaction and reports what was observed.
  //
  // Target model:
  //   - The selected target asserts ready in the (ready_dly+1)-th cycle in
  //     which its valid is seen.
  //   - While the selected target is waiting, every non-selected target
  //     holds ready high.
  //
  // Returned observations:
  //   lat     number of cycles cpu_mem_valid was high, up to and including
  //           the cycle in which cpu_mem_ready was seen
  //   pulses  number of ready strobes seen, including the cycle after the
  //           response
  //
  // The wait is bounded at 600 cycles. If the bound expires, pulses is 0.
  task automatic run_xact(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int ready_dly,
                          output int lat, output int vcyc, output logic [NT-1:0] vmask,
                          output logic [31:0] rdata, output logic [31:0] t_addr,
                          output logic [31:0] t_wdata, output logic [3:0] t_wstrb,
                          output int pulses);
    lat = 1; vcyc = 0; vmask = '0; rdata = '0; pulses = 0;
    t_addr = '0; t_wdata = '0; t_wstrb = '0;
    @(negedge clk);
    cpu_mem_valid = 1'b1;
    cpu_mem_addr  = addr;
    cpu_mem_wdata = wdata;
    cpu_mem_wstrb = wstrb;
    tgt_mem_ready = '0;
    while (lat < 600) begin
      @(negedge clk);
      lat++;
      if (cpu_mem_ready === 1'b1) break;
      if (tgt_mem_valid != '0) begin
        vcyc++;
        vmask   = vmask | tgt_mem_valid;
        t_addr  = tgt_mem_addr;
        t_wdata = tgt_mem_wdata;
        t_wstrb = tgt_mem_wstrb;
        tgt_mem_ready = (vcyc > ready_dly) ? tgt_mem_valid : ~tgt_mem_valid;
      end else begin
        tgt_mem_ready = '0;
      end
    end
    pulses = (cpu_mem_ready === 1'b1) ? 1 : 0;
    rdata  = cpu_mem_rdata;
    cpu_mem_valid = 1'b0;
    tgt_mem_ready = '0;
    @(negedge clk);
    if (cpu_mem_ready === 1'b1) pulses++;
    if (tgt_mem_valid != '0) vcyc++;
  endtask

  // Observation variables shared by the test tasks.
  int            lat, vcyc, pulses;
  logic [NT-1:0] vmask;
  logic [31:0]   rdata, t_addr, t_wdata;
  logic [3:0]    t_wstrb;

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({cpu_mem_ready, tgt_mem_valid, tgt_mem_wstrb} !== '0) begin
      n_errors++;
      $display("FAIL reset_ctrl: ready/valid/wstrb=%b required 0",
               {cpu_mem_ready, tgt_mem_valid, tgt_mem_wstrb});
    end
    n_checks++;
    if ({cpu_mem_rdata, tgt_mem_addr, tgt_mem_wdata} !== '0) begin
      n_errors++;
      $display("FAIL reset_data: rdata/addr/wdata=%h required 0",
               {cpu_mem_rdata, tgt_mem_addr, tgt_mem_wdata});
    end
    n_checks++;
    if ({err_valid, err_addr, err_cnt} !== '0) begin
      n_errors++;
      $display("FAIL reset_err: err=%h required 0", {err_valid, err_addr, err_cnt});
    end
    rst = 1'b0;
  endtask

  task automatic test_read_delayed();
    run_xact(32'h0001_0000, 32'h0, 4'b0000, 2, lat, vcyc, vmask, rdata, t_addr, t_wdata, t_wstrb, pulses);
    n_checks++;
    if (vmask !== 4'b0010) begin
      n_errors++;
      $display("FAIL rd1_sel: valid mask %b required 0010", vmask);
    end
    n_checks++;
    if (vcyc !== 3) begin
      n_errors++;
      $display("FAIL rd1_vcyc: valid cycles %0d required 3", vcyc);
    end
    n_checks++;
    if (lat !== 5) begin
      n_errors++;
      $display("FAIL rd1_lat: latency %0d required 5", lat);
    end
    n_checks++;
    if (rdata !== 32'h1234_5678) begin
      n_errors++;
      $display("FAIL rd1_rdata: %h required 12345678", rdata);
    end
    n_checks++;
    if (pulses !== 1) begin
      n_errors++;
      $display("FAIL rd1_pulses: %0d required 1", pulses);
    end
    n_checks++;
    if ({t_addr, t_wstrb} !== {32'h0001_0000, 4'b0000}) begin
      n_errors++;
      $display("FAIL rd1_fields: addr %h wstrb %b required 00010000/0000", t_addr, t_wstrb);
    end
  endtask

  task automatic test_write_immediate();
    run_xact(32'h0000_0040, 32'hA5A5_A5A5, 4'b0011, 0, lat, vcyc, vmask, rdata, t_addr, t_wdata, t_wstrb, pulses);
    n_checks++;
    if (vmask !== 4'b0001) begin
      n_errors++;
      $display("FAIL wr_sel: valid mask %b required 0001", vmask);
    end
    n_checks++;
    if ({t_addr, t_wdata, t_wstrb} !== {32'h0000_0040, 32'hA5A5_A5A5, 4'b0011}) begin
      n_errors++;
      $display("FAIL wr_fields: %h/%h/%b required 00000040/a5a5a5a5/0011", t_addr, t_wdata, t_wstrb);
    end
    n_checks++;
    if (lat !== 3 || pulses !== 1) begin
      n_errors++;
      $display("FAIL wr_lat: latency %0d pulses %0d required 3/1", lat, pulses);
    end
    n_checks++;
    if (rdata !== 32'hCAFE_0000) begin
      n_errors++;
      $display("FAIL wr_rdata: %h required cafe0000", rdata);
    end
    n_checks++;
    if (err_cnt !== 8'd0 || err_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL wr_noerr: err_cnt %h err_valid %b required 0/0", err_cnt, err_valid);
    end
  endtask

  task automatic test_other_targets();
    run_xact(32'h0008_0000, 32'h0, 4'b0000, 1, lat, vcyc, vmask, rdata, t_addr, t_wdata, t_wstrb, pulses);
    n_checks++;
    if (vmask !== 4'b0100 || rdata !== 32'h2222_2222 || lat !== 4) begin
      n_errors++;
      $display("FAIL tgt2: mask %b rdata %h lat %0d required 0100/22222222/4", vmask, rdata, lat);
    end
    run_xact(32'h2000_0010, 32'h0, 4'b0000, 0, lat, vcyc, vmask, rdata, t_addr, t_wdata, t_wstrb, pulses);
    n_checks++;
    if (vmask !== 4'b1000 || rdata !== 32'h3333_3333 || lat !== 3) begin
      n_errors++;
      $display("FAIL tgt3: mask %b rdata %h lat %0d required 1000/33333333/3", vmask, rdata, lat);
    end
  endtask

  task automatic test_overlap();
    run_xact(32'h0000_0100, 32'h0, 4'b0000, 0, lat, vcyc, vmask, rdata, t_addr, t_wdata, t_wstrb, pulses);
    n_checks++;
    if (vmask !== 4'b0001 || rdata !== 32'hCAFE_0000) begin
      n_errors++;
      $display("FAIL overlap: mask %b rdata %h required 0001/cafe0000", vmask, rdata);
    end
  endtask

  task automatic test_decode_error();
    run_xact(32'hF000_0000, 32'h0, 4'b0000, 0, lat, vcyc, vmask, rdata, t_addr, t_wdata, t_wstrb, pulses);
    n_checks++;
    if (vmask !== 4'b0000) begin
      n_errors++;
      $display("FAIL derr_novalid: mask %b required 0000", vmask);
    end
    n_checks++;
    if (rdata !== 32'hDEAD_BEEF || lat !== 3 || pulses !== 1) begin
      n_errors++;
      $display("FAIL derr_resp: rdata %h lat %0d pulses %0d required deadbeef/3/1", rdata, lat, pulses);
    end
    n_checks++;
    if ({err_valid, err_addr, err_cnt} !== {1'b1, 32'hF000_0000, 8'd1}) begin
      n_errors++;
      $display("FAIL derr_rec: valid %b addr %h cnt %h required 1/f0000000/01", err_valid, err_addr, err_cnt);
    end
    // An unmapped write must never reach a target.
    run_xact(32'h8000_0004, 32'h1111_2222, 4'b1111, 0, lat, vcyc, vmask, rdata, t_addr, t_wdata, t_wstrb, pulses);
    n_checks++;
    if (vmask !== 4'b0000 || err_cnt !== 8'd2 || err_addr !== 32'h8000_0004) begin
      n_errors++;
      $display("FAIL derr_write: mask %b cnt %h addr %h required 0000/02/80000004", vmask, err_cnt, err_addr);
    end
  endtask

  task automatic test_err_saturation();
    // Count is 2 on entry; 252 more errors bring it to 254.
    for (int i = 0; i < 252; i++)
      run_xact(32'hF000_0000 | i, 32'h0, 4'b0000, 0, lat, vcyc, vmask, rdata, t_addr, t_wdata, t_wstrb, pulses);
    n_checks++;
    if (err_cnt !== 8'hFE) begin
      n_errors++;
      $display("FAIL sat_fe: err_cnt %h required fe", err_cnt);
    end
    for (int i = 0; i < 48; i++)
      run_xact(32'hF100_0000 | i, 32'h0, 4'b0000, 0, lat, vcyc, vmask, rdata, t_addr, t_wdata, t_wstrb, pulses);
    n_checks++;
    if (err_cnt !== 8'hFF || err_addr !== 32'hF100_002F) begin
      n_errors++;
      $display("FAIL sat_ff: err_cnt %h addr %h required ff/f100002f", err_cnt, err_addr);
    end
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_checks++;
    if ({err_valid, err_addr, err_cnt} !== '0) begin
      n_errors++;
      $display("FAIL err_clr: valid %b addr %h cnt %h required 0", err_valid, err_addr, err_cnt);
    end
  endtask

  task automatic test_err_clr_collision();
    run_xact(32'hE000_0000, 32'h0, 4'b0000, 0, lat, vcyc, vmask, rdata, t_addr, t_wdata, t_wstrb, pulses);
    run_xact(32'hE000_0000, 32'h0, 4'b0000, 0, lat, vcyc, vmask, rdata, t_addr, t_wdata, t_wstrb, pulses);
    n_checks++;
    if (err_cnt !== 8'd2) begin
      n_errors++;
      $display("FAIL coll_pre: err_cnt %h required 02", err_cnt);
    end
    // err_clr is raised exactly in the ERR-state cycle.
    @(negedge clk);
    cpu_mem_valid = 1'b1;
    cpu_mem_addr  = 32'hE000_0004;
    cpu_mem_wstrb = 4'b0000;
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    cpu_mem_valid = 1'b0;
    n_checks++;
    if ({cpu_mem_ready, err_valid, err_addr, err_cnt} !== {1'b1, 1'b1, 32'hE000_0004, 8'd1}) begin
      n_errors++;
      $display("FAIL coll: ready %b valid %b addr %h cnt %h required 1/1/e0000004/01",
               cpu_mem_ready, err_valid, err_addr, err_cnt);
    end
    @(negedge clk);
  endtask

`ifdef MCU_BUS_TIMEOUT_EN
  task automatic test_timeout();
    logic [7:0] cnt0;
    cnt0 = err_cnt;
    run_xact(32'h2000_0000, 32'h0, 4'b0000, 1000, lat, vcyc, vmask, rdata, t_addr, t_wdata, t_wstrb, pulses);
    n_checks++;
    if (vcyc !== 8 || rdata !== 32'hDEAD_BEEF || pulses !== 1) begin
      n_errors++;
      $display("FAIL to_expire: vcyc %0d rdata %h pulses %0d required 8/deadbeef/1", vcyc, rdata, pulses);
    end
    n_checks++;
    if (err_cnt !== cnt0 + 8'd1 || err_addr !== 32'h2000_0000) begin
      n_errors++;
      $display("FAIL to_err: cnt %h addr %h required %h/20000000", err_cnt, err_addr, cnt0 + 8'd1);
    end
    cnt0 = err_cnt;
    run_xact(32'h2000_0000, 32'h0, 4'b0000, 7, lat, vcyc, vmask, rdata, t_addr, t_wdata, t_wstrb, pulses);
    n_checks++;
    if (vcyc !== 8 || rdata !== 32'h3333_3333 || err_cnt !== cnt0) begin
      n_errors++;
      $display("FAIL to_race: vcyc %0d rdata %h cnt %h required 8/33333333/%h", vcyc, rdata, err_cnt, cnt0);
    end
  endtask
`endif

  task automatic test_reset_active();
    @(negedge clk);
    cpu_mem_valid = 1'b1;
    cpu_mem_addr  = 32'h2000_0010;
    cpu_mem_wstrb = 4'b0000;
    tgt_mem_ready = '0;
    @(negedge clk);
    n_checks++;
    if (tgt_mem_valid !== 4'b1000) begin
      n_errors++;
      $display("FAIL rsta_active: valid %b required 1000", tgt_mem_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    cpu_mem_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({cpu_mem_ready, tgt_mem_valid, tgt_mem_wstrb, cpu_mem_rdata, tgt_mem_addr, tgt_mem_wdata,
         err_valid, err_addr, err_cnt} !== '0) begin
      n_errors++;
      $display("FAIL rsta_zero: ready %b valid %b rdata %h addr %h err %b/%h required all 0",
               cpu_mem_ready, tgt_mem_valid, cpu_mem_rdata, tgt_mem_addr, err_valid, err_cnt);
    end
    @(negedge clk);
    n_checks++;
    if (cpu_mem_ready !== 1'b0 || tgt_mem_valid !== 4'b0000) begin
      n_errors++;
      $display("FAIL rsta_quiet: ready %b valid %b required 0/0000", cpu_mem_ready, tgt_mem_valid);
    end
    run_xact(32'h2000_0010, 32'h0, 4'b0000, 1, lat, vcyc, vmask, rdata, t_addr, t_wdata, t_wstrb, pulses);
    n_checks++;
    if (vmask !== 4'b1000 || rdata !== 32'h3333_3333 || lat !== 4 || pulses !== 1) begin
      n_errors++;
      $display("FAIL rsta_next: mask %b rdata %h lat %0d pulses %0d required 1000/33333333/4/1",
               vmask, rdata, lat, pulses);
    end
  endtask

  initial begin
    rst           = 1'b1;
    cpu_mem_valid = 1'b0;
    cpu_mem_addr  = '0;
    cpu_mem_wdata = '0;
    cpu_mem_wstrb = '0;
    tgt_mem_ready = '0;
    err_clr       = 1'b0;
    tgt_mem_rdata = {32'h3333_3333, 32'h2222_2222, 32'h1234_5678, 32'hCAFE_0000};

    test_reset();
    test_read_delayed();
    test_write_immediate();
    test_other_targets();
    test_overlap();
    test_decode_error();
    test_err_saturation();
    test_err_clr_collision();
`ifdef MCU_BUS_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_active();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
